// File: rtl/timer_bus_bridge_if.sv
// Core-side load/store request and response channels of the timer bridge.
// The core drives the master modport and the bridge uses the slave modport.
interface timer_bus_bridge_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [3:0]  req_be_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );
endinterface

// File: rtl/timer_bus_bridge.sv
// Bridges single-beat core loads/stores onto the CSR unit's mtime/mtimecmp
// port. Partial stores are done as read-modify-write. One request in flight.
module timer_bus_bridge #(
  parameter logic [31:0] MTIME_LO_ADDR    = 32'h0200_BFF8,
  parameter logic [31:0] MTIME_HI_ADDR    = 32'h0200_BFFC,
  parameter logic [31:0] MTIMECMP_LO_ADDR = 32'h0200_4000,
  parameter logic [31:0] MTIMECMP_HI_ADDR = 32'h0200_4004
) (
  input  logic                 clk,
  input  logic                 rst,
  timer_bus_bridge_if.slave    bus,
  output logic                 mtimeWe_o,
  output logic [31:0]          mtimeAddress_o,
  output logic [31:0]          mtimeData_o,
  input  logic [31:0]          mtimeData_i
);

  typedef enum logic [2:0] {IDLE, READ, RMW_READ, WRITE, RESP} state_t;

  localparam logic [31:0] WIN_ADDR [4] = '{MTIME_LO_ADDR, MTIME_HI_ADDR,
                                            MTIMECMP_LO_ADDR, MTIMECMP_HI_ADDR};

  state_t      state_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  be_reg;
  logic [31:0] merge_reg;
  logic        req_ready_reg;
  logic        resp_valid_reg;
  logic [31:0] resp_rdata_reg;
  logic        resp_err_reg;
  logic        mtime_we_reg;

  logic [3:0]  hit_vec;
  logic [31:0] merged_word;
  logic        accept;
  logic        req_bad;

  // The timer port address and write data come straight from the latched
  // address and the (possibly merged) write word, so they hold between requests.
  assign mtimeAddress_o   = addr_reg;
  assign mtimeData_o      = merge_reg;
  assign mtimeWe_o        = mtime_we_reg;
  assign bus.req_ready_o  = req_ready_reg;
  assign bus.resp_valid_o = resp_valid_reg;
  assign bus.resp_rdata_o = resp_rdata_reg;
  assign bus.resp_err_o   = resp_err_reg;

  assign accept  = bus.req_valid_i & req_ready_reg;
  assign req_bad = (bus.req_addr_i[1:0] != 2'b00) | ~(|hit_vec);

  genvar gi;
  // Window decode: one comparator per timer register.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_hit
      assign hit_vec[gi] = (bus.req_addr_i == WIN_ADDR[gi]);
    end
  endgenerate

  // Byte merge for partial stores: enabled bytes from the store, rest from the CSR.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      assign merged_word[8*gi +: 8] = be_reg[gi] ? wdata_reg[8*gi +: 8]
                                                 : mtimeData_i[8*gi +: 8];
    end
  endgenerate

  // Request sequencer with all core- and CSR-facing outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      be_reg         <= '0;
      merge_reg      <= '0;
      req_ready_reg  <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_rdata_reg <= '0;
      resp_err_reg   <= 1'b0;
      mtime_we_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          req_ready_reg <= 1'b1;
          if (accept) begin
            req_ready_reg  <= 1'b0;
            addr_reg       <= bus.req_addr_i;
            wdata_reg      <= bus.req_wdata_i;
            be_reg         <= bus.req_be_i;
            resp_rdata_reg <= '0;
            resp_err_reg   <= 1'b0;
            if (req_bad) begin
              resp_err_reg   <= 1'b1;
              resp_valid_reg <= 1'b1;
              state_reg      <= RESP;
            end else if (!bus.req_we_i) begin
              state_reg <= READ;
            end else if (bus.req_be_i == 4'b1111) begin
              merge_reg    <= bus.req_wdata_i;
              mtime_we_reg <= 1'b1;
              state_reg    <= WRITE;
            end else if (bus.req_be_i == 4'b0000) begin
              resp_valid_reg <= 1'b1;
              state_reg      <= RESP;
            end else begin
              state_reg <= RMW_READ;
            end
          end
        end
        READ: begin
          resp_rdata_reg <= mtimeData_i;
          resp_valid_reg <= 1'b1;
          state_reg      <= RESP;
        end
        RMW_READ: begin
          merge_reg    <= merged_word;
          mtime_we_reg <= 1'b1;
          state_reg    <= WRITE;
        end
        WRITE: begin
          mtime_we_reg   <= 1'b0;
          resp_valid_reg <= 1'b1;
          state_reg      <= RESP;
        end
        RESP: begin
          if (bus.resp_ready_i) begin
            resp_valid_reg <= 1'b0;
            req_ready_reg  <= 1'b1;
            state_reg      <= IDLE;
          end
        end
        default: begin
          state_reg      <= IDLE;
          mtime_we_reg   <= 1'b0;
          resp_valid_reg <= 1'b0;
          req_ready_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule
